// File: rtl/fp_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_ctrl_if
// Brief    : Dispatch, FALU, FDIVSQRT and writeback bundle for fp_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_issue_ctrl_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
);
    logic              valid_i;
    logic              ready_o;
    logic [4:0]        op_i;
    logic [2:0]        rm_i;
    logic [1:0]        fmt_i;
    logic [TAG_W-1:0]  tag_i;
    logic [2:0]        frm_i;
    logic              flush_i;
    logic              illegal_o;

    logic              falu_valid_o;
    logic [4:0]        falu_op_o;
    logic [2:0]        falu_rm_o;
    logic [1:0]        falu_fmt_o;
    logic [DATA_W-1:0] falu_res_i;
    logic [4:0]        falu_flags_i;

    logic              ds_start_o;
    logic [4:0]        ds_op_o;
    logic [2:0]        ds_rm_o;
    logic [1:0]        ds_fmt_o;
    logic              ds_kill_o;
    logic              ds_done_i;
    logic [DATA_W-1:0] ds_res_i;
    logic [4:0]        ds_flags_i;

    logic              wb_valid_o;
    logic [TAG_W-1:0]  wb_tag_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [4:0]        wb_flags_o;

    modport slave (
        input  valid_i, op_i, rm_i, fmt_i, tag_i, frm_i, flush_i,
        input  falu_res_i, falu_flags_i, ds_done_i, ds_res_i, ds_flags_i,
        output ready_o, illegal_o,
        output falu_valid_o, falu_op_o, falu_rm_o, falu_fmt_o,
        output ds_start_o, ds_op_o, ds_rm_o, ds_fmt_o, ds_kill_o,
        output wb_valid_o, wb_tag_o, wb_data_o, wb_flags_o
    );

    modport master (
        output valid_i, op_i, rm_i, fmt_i, tag_i, frm_i, flush_i,
        output falu_res_i, falu_flags_i, ds_done_i, ds_res_i, ds_flags_i,
        input  ready_o, illegal_o,
        input  falu_valid_o, falu_op_o, falu_rm_o, falu_fmt_o,
        input  ds_start_o, ds_op_o, ds_rm_o, ds_fmt_o, ds_kill_o,
        input  wb_valid_o, wb_tag_o, wb_data_o, wb_flags_o
    );
endinterface
`default_nettype wire

// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_ctrl
// Brief    : FP issue/writeback control: routes ops to FALU or FDIVSQRT,
//            resolves dynamic rm and arbitrates the single writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module fp_issue_ctrl #(
    parameter int FALU_LAT = 3,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    fp_issue_ctrl_if.slave     bus
);
    localparam logic [4:0] OP_FLW        = 5'd0;
    localparam logic [4:0] OP_FSW        = 5'd1;
    localparam logic [4:0] OP_RM_FIRST   = 5'd2;
    localparam logic [4:0] OP_DIVS       = 5'd11;
    localparam logic [4:0] OP_FSQRTS     = 5'd12;
    localparam logic [4:0] OP_RM_LAST    = 5'd12;
    localparam logic [4:0] OP_NONE       = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic              falu_valid_q, falu_valid_d;
    logic [4:0]        falu_op_q, falu_op_d;
    logic [2:0]        falu_rm_q, falu_rm_d;
    logic [1:0]        falu_fmt_q, falu_fmt_d;
    logic [TAG_W-1:0]  falu_tag_q, falu_tag_d;
    logic [FALU_LAT-1:0] sr_vld_q, sr_vld_d;
    logic [TAG_W-1:0]  sr_tag_q [FALU_LAT];
    logic [TAG_W-1:0]  sr_tag_d [FALU_LAT];
    logic              ds_start_q, ds_start_d;
    logic [4:0]        ds_op_q, ds_op_d;
    logic [2:0]        ds_rm_q, ds_rm_d;
    logic [1:0]        ds_fmt_q, ds_fmt_d;
    logic [TAG_W-1:0]  ds_tag_q, ds_tag_d;
    logic              ds_kill_q, ds_kill_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [4:0]        hold_flags_q, hold_flags_d;
    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_flags_q, wb_flags_d;

    logic [2:0] eff_rm;
    logic       uses_rm, rm_bad, is_ds, is_ill, hold_pend, ready;
    logic       accept_falu, accept_ds, res_vld, ds_wb;

    // Op classification and acceptance
    always_comb begin
        eff_rm    = (bus.rm_i == 3'b111) ? bus.frm_i : bus.rm_i;
        uses_rm   = (bus.op_i >= OP_RM_FIRST) && (bus.op_i <= OP_RM_LAST);
        rm_bad    = uses_rm && ((eff_rm == 3'b101) || (eff_rm == 3'b110));
        is_ds     = (bus.op_i == OP_DIVS) || (bus.op_i == OP_FSQRTS);
        is_ill    = (bus.op_i == OP_FLW) || (bus.op_i == OP_FSW) ||
                    (bus.op_i == OP_NONE) || rm_bad;
        hold_pend = (state_q == ST_HOLD);
        if (bus.flush_i)      ready = 1'b0;
        else if (is_ill)      ready = 1'b1;
        else if (is_ds)       ready = (state_q == ST_IDLE);
        else                  ready = ~hold_pend;
        accept_falu = bus.valid_i && ready && !is_ill && !is_ds;
        accept_ds   = bus.valid_i && ready && !is_ill && is_ds;
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = bus.valid_i && ready && is_ill;
        falu_valid_d = accept_falu;
        falu_op_d    = falu_op_q;
        falu_rm_d    = falu_rm_q;
        falu_fmt_d   = falu_fmt_q;
        falu_tag_d   = falu_tag_q;
        ds_start_d   = 1'b0;
        ds_op_d      = ds_op_q;
        ds_rm_d      = ds_rm_q;
        ds_fmt_d     = ds_fmt_q;
        ds_tag_d     = ds_tag_q;
        ds_kill_d    = 1'b0;
        hold_data_d  = hold_data_q;
        hold_flags_d = hold_flags_q;
        wb_tag_d     = wb_tag_q;
        wb_data_d    = wb_data_q;
        wb_flags_d   = wb_flags_q;
        ds_wb        = 1'b0;

        if (accept_falu) begin
            falu_op_d  = bus.op_i;
            falu_rm_d  = eff_rm;
            falu_fmt_d = bus.fmt_i;
            falu_tag_d = bus.tag_i;
        end

        // Shift input is the issue register so the last stage lines up with the FALU result
        sr_vld_d[0] = falu_valid_q;
        sr_tag_d[0] = falu_tag_q;
        for (int i = 1; i < FALU_LAT; i++) begin
            sr_vld_d[i] = sr_vld_q[i-1];
            sr_tag_d[i] = sr_tag_q[i-1];
        end
        res_vld = sr_vld_q[FALU_LAT-1];

        case (state_q)
            ST_IDLE: begin
                if (accept_ds) begin
                    ds_start_d = 1'b1;
                    ds_op_d    = bus.op_i;
                    ds_rm_d    = eff_rm;
                    ds_fmt_d   = bus.fmt_i;
                    ds_tag_d   = bus.tag_i;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.ds_done_i) begin
                    if (res_vld) begin
                        hold_data_d  = bus.ds_res_i;
                        hold_flags_d = bus.ds_flags_i;
                        state_d      = ST_HOLD;
                    end else begin
                        ds_wb   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!res_vld) begin
                    ds_wb   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // FALU result wins: it has no way to stall
        wb_valid_d = res_vld || ds_wb;
        if (res_vld) begin
            wb_tag_d   = sr_tag_q[FALU_LAT-1];
            wb_data_d  = bus.falu_res_i;
            wb_flags_d = bus.falu_flags_i;
        end else if (ds_wb) begin
            wb_tag_d   = ds_tag_q;
            wb_data_d  = hold_pend ? hold_data_q  : bus.ds_res_i;
            wb_flags_d = hold_pend ? hold_flags_q : bus.ds_flags_i;
        end

        if (bus.flush_i) begin
            ds_kill_d  = (state_q == ST_BUSY);
            state_d    = ST_IDLE;
            wb_valid_d = 1'b0;
            sr_vld_d   = '0;
            ds_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            illegal_q    <= 1'b0;
            falu_valid_q <= 1'b0;
            falu_op_q    <= '0;
            falu_rm_q    <= '0;
            falu_fmt_q   <= '0;
            falu_tag_q   <= '0;
            sr_vld_q     <= '0;
            for (int i = 0; i < FALU_LAT; i++) sr_tag_q[i] <= '0;
            ds_start_q   <= 1'b0;
            ds_op_q      <= '0;
            ds_rm_q      <= '0;
            ds_fmt_q     <= '0;
            ds_tag_q     <= '0;
            ds_kill_q    <= 1'b0;
            hold_data_q  <= '0;
            hold_flags_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
            wb_flags_q   <= '0;
        end else begin
            state_q      <= state_d;
            illegal_q    <= illegal_d;
            falu_valid_q <= falu_valid_d;
            falu_op_q    <= falu_op_d;
            falu_rm_q    <= falu_rm_d;
            falu_fmt_q   <= falu_fmt_d;
            falu_tag_q   <= falu_tag_d;
            sr_vld_q     <= sr_vld_d;
            for (int i = 0; i < FALU_LAT; i++) sr_tag_q[i] <= sr_tag_d[i];
            ds_start_q   <= ds_start_d;
            ds_op_q      <= ds_op_d;
            ds_rm_q      <= ds_rm_d;
            ds_fmt_q     <= ds_fmt_d;
            ds_tag_q     <= ds_tag_d;
            ds_kill_q    <= ds_kill_d;
            hold_data_q  <= hold_data_d;
            hold_flags_q <= hold_flags_d;
            wb_valid_q   <= wb_valid_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
            wb_flags_q   <= wb_flags_d;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.illegal_o    = illegal_q;
    assign bus.falu_valid_o = falu_valid_q;
    assign bus.falu_op_o    = falu_op_q;
    assign bus.falu_rm_o    = falu_rm_q;
    assign bus.falu_fmt_o   = falu_fmt_q;
    assign bus.ds_start_o   = ds_start_q;
    assign bus.ds_op_o      = ds_op_q;
    assign bus.ds_rm_o      = ds_rm_q;
    assign bus.ds_fmt_o     = ds_fmt_q;
    assign bus.ds_kill_o    = ds_kill_q;
    assign bus.wb_valid_o   = wb_valid_q;
    assign bus.wb_tag_o     = wb_tag_q;
    assign bus.wb_data_o    = wb_data_q;
    assign bus.wb_flags_o   = wb_flags_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fp_issue_ctrl
// Brief    : Directed testbench for fp_issue_ctrl with a fixed-latency FALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_issue_ctrl;
    localparam int FALU_LAT = 3;
    localparam int TAG_W    = 4;
    localparam int DATA_W   = 64;

    localparam logic [4:0] OP_FLW   = 5'd0;
    localparam logic [4:0] OP_FADDS = 5'd2;
    localparam logic [4:0] OP_FSUBS = 5'd3;
    localparam logic [4:0] OP_FMULS = 5'd4;
    localparam logic [4:0] OP_DIVS  = 5'd11;
    localparam logic [4:0] OP_NONE  = 5'd31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    fp_issue_ctrl_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    fp_issue_ctrl #(.FALU_LAT(FALU_LAT), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // FALU model: result presented FALU_LAT cycles after falu_valid_o, data encodes op/rm/fmt
    logic [FALU_LAT-1:0] fp_vld = '0;
    logic [9:0]          fp_info [FALU_LAT];
    always @(posedge clk) begin
        fp_vld     <= {fp_vld[FALU_LAT-2:0], bus.falu_valid_o};
        fp_info[0] <= {bus.falu_op_o, bus.falu_rm_o, bus.falu_fmt_o};
        for (int i = 1; i < FALU_LAT; i++) fp_info[i] <= fp_info[i-1];
    end
    assign bus.falu_res_i   = fp_vld[FALU_LAT-1] ? {32'hF00D_0000, 22'h0, fp_info[FALU_LAT-1]}
                                                 : 64'hDEAD_BEEF_DEAD_BEEF;
    assign bus.falu_flags_i = fp_vld[FALU_LAT-1] ? fp_info[FALU_LAT-1][9:5] : 5'h1F;

    function automatic logic [63:0] exp_falu(input logic [4:0] op, input logic [2:0] rm,
                                             input logic [1:0] fmt);
        return {32'hF00D_0000, 22'h0, op, rm, fmt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rm,
                         input logic [1:0] fmt, input logic [TAG_W-1:0] tag);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.rm_i    = rm;
        bus.fmt_i   = fmt;
        bus.tag_i   = tag;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        bus.flush_i = 1'b0; bus.frm_i = 3'b000; bus.ds_done_i = 1'b0;
        bus.ds_res_i = '0; bus.ds_flags_i = '0;
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        rst = 1'b1;
        repeat (2) step();
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid_o); end
        vectors++; if (bus.falu_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_falu_valid got %b exp 0", bus.falu_valid_o); end
        vectors++; if (bus.ds_start_o !== 1'b0 || bus.ds_kill_o !== 1'b0) begin miscompares++; $display("FAIL reset_ds got start=%b kill=%b exp 0 0", bus.ds_start_o, bus.ds_kill_o); end
        vectors++; if (bus.illegal_o !== 1'b0 || bus.wb_tag_o !== '0) begin miscompares++; $display("FAIL reset_misc got ill=%b tag=%0h exp 0 0", bus.illegal_o, bus.wb_tag_o); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.ready_o); end
    endtask

    task automatic test_falu_single();
        drive(1'b1, OP_FADDS, 3'b000, 2'b00, 4'd3);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b exp 1", bus.ready_o); end
        step();
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        vectors++; if (bus.falu_valid_o !== 1'b1 || bus.falu_rm_o !== 3'b000 || bus.falu_op_o !== OP_FADDS) begin miscompares++; $display("FAIL single_issue got v=%b op=%0d rm=%0d exp 1 2 0", bus.falu_valid_o, bus.falu_op_o, bus.falu_rm_o); end
        repeat (3) step();
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_wb_early got %b exp 0", bus.wb_valid_o); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd3) begin miscompares++; $display("FAIL single_wb got v=%b tag=%0d exp 1 3", bus.wb_valid_o, bus.wb_tag_o); end
        vectors++; if (bus.wb_data_o !== exp_falu(OP_FADDS, 3'b000, 2'b00) || bus.wb_flags_o !== OP_FADDS) begin miscompares++; $display("FAIL single_data got %h/%h exp %h/%h", bus.wb_data_o, bus.wb_flags_o, exp_falu(OP_FADDS, 3'b000, 2'b00), OP_FADDS); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_wb_end got %b exp 0", bus.wb_valid_o); end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_FADDS, 3'b000, 2'b00, 4'd1);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0 got %b exp 1", bus.ready_o); end
        step();
        drive(1'b1, OP_FMULS, 3'b001, 2'b01, 4'd2);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1 got %b exp 1", bus.ready_o); end
        step();
        drive(1'b1, OP_FSUBS, 3'b011, 2'b00, 4'd3);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2 got %b exp 1", bus.ready_o); end
        step();
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        repeat (2) step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd1 || bus.wb_data_o !== exp_falu(OP_FADDS, 3'b000, 2'b00)) begin miscompares++; $display("FAIL b2b_wb1 got v=%b tag=%0d data=%h exp 1 1 %h", bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o, exp_falu(OP_FADDS, 3'b000, 2'b00)); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd2 || bus.wb_data_o !== exp_falu(OP_FMULS, 3'b001, 2'b01)) begin miscompares++; $display("FAIL b2b_wb2 got v=%b tag=%0d data=%h exp 1 2 %h", bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o, exp_falu(OP_FMULS, 3'b001, 2'b01)); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd3 || bus.wb_data_o !== exp_falu(OP_FSUBS, 3'b011, 2'b00)) begin miscompares++; $display("FAIL b2b_wb3 got v=%b tag=%0d data=%h exp 1 3 %h", bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o, exp_falu(OP_FSUBS, 3'b011, 2'b00)); end
        idle_cycles(3);
    endtask

    task automatic test_divsqrt();
        bus.frm_i = 3'b010;
        drive(1'b1, OP_DIVS, 3'b111, 2'b00, 4'd5);
        step();
        vectors++; if (bus.ds_start_o !== 1'b1 || bus.ds_rm_o !== 3'b010 || bus.ds_op_o !== OP_DIVS) begin miscompares++; $display("FAIL ds_start got s=%b rm=%0d op=%0d exp 1 2 11", bus.ds_start_o, bus.ds_rm_o, bus.ds_op_o); end
        drive(1'b1, OP_DIVS, 3'b000, 2'b00, 4'd6);
        vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL ds_busy_ready got %b exp 0", bus.ready_o); end
        step();
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        vectors++; if (bus.ds_start_o !== 1'b0) begin miscompares++; $display("FAIL ds_start_pulse got %b exp 0", bus.ds_start_o); end
        repeat (18) step();
        bus.ds_done_i = 1'b1; bus.ds_res_i = 64'h0123_4567_89AB_CDEF; bus.ds_flags_i = 5'h11;
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL ds_wb_early got %b exp 0", bus.wb_valid_o); end
        step();
        bus.ds_done_i = 1'b0;
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd5) begin miscompares++; $display("FAIL ds_wb got v=%b tag=%0d exp 1 5", bus.wb_valid_o, bus.wb_tag_o); end
        vectors++; if (bus.wb_data_o !== 64'h0123_4567_89AB_CDEF || bus.wb_flags_o !== 5'h11) begin miscompares++; $display("FAIL ds_data got %h/%h exp 0123456789abcdef/11", bus.wb_data_o, bus.wb_flags_o); end
        bus.frm_i = 3'b000;
        step();
        // done while IDLE must be ignored
        bus.ds_done_i = 1'b1;
        step();
        bus.ds_done_i = 1'b0;
        step();
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL ds_idle_done got %b exp 0", bus.wb_valid_o); end
        idle_cycles(2);
    endtask

    task automatic test_conflict();
        drive(1'b1, OP_DIVS, 3'b000, 2'b00, 4'd9);
        step();
        drive(1'b1, OP_FADDS, 3'b000, 2'b00, 4'd1);
        step();
        drive(1'b1, OP_FMULS, 3'b000, 2'b00, 4'd2);
        step();
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        repeat (2) step();
        bus.ds_done_i = 1'b1; bus.ds_res_i = 64'h0000_0000_0000_CAFE; bus.ds_flags_i = 5'h03;
        step();
        bus.ds_done_i = 1'b0; bus.ds_res_i = 64'h5555_5555_5555_5555; bus.ds_flags_i = 5'h1E;
        #1;
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd1) begin miscompares++; $display("FAIL cf_wb1 got v=%b tag=%0d exp 1 1", bus.wb_valid_o, bus.wb_tag_o); end
        vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL cf_hold_ready got %b exp 0", bus.ready_o); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd2) begin miscompares++; $display("FAIL cf_wb2 got v=%b tag=%0d exp 1 2", bus.wb_valid_o, bus.wb_tag_o); end
        vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL cf_hold_ready2 got %b exp 0", bus.ready_o); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd9 || bus.wb_data_o !== 64'h0000_0000_0000_CAFE || bus.wb_flags_o !== 5'h03) begin miscompares++; $display("FAIL cf_wb_ds got v=%b tag=%0d data=%h fl=%h exp 1 9 cafe 03", bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o, bus.wb_flags_o); end
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL cf_idle_ready got %b exp 1", bus.ready_o); end
        step();
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL cf_wb_end got %b exp 0", bus.wb_valid_o); end
        idle_cycles(2);
    endtask

    task automatic test_illegal();
        drive(1'b1, OP_FMULS, 3'b101, 2'b00, 4'd1);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL ill_rm_ready got %b exp 1", bus.ready_o); end
        step();
        vectors++; if (bus.illegal_o !== 1'b1 || bus.falu_valid_o !== 1'b0) begin miscompares++; $display("FAIL ill_rm got ill=%b fv=%b exp 1 0", bus.illegal_o, bus.falu_valid_o); end
        drive(1'b1, OP_FLW, 3'b000, 2'b00, 4'd2);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL ill_flw_ready got %b exp 1", bus.ready_o); end
        step();
        vectors++; if (bus.illegal_o !== 1'b1 || bus.falu_valid_o !== 1'b0) begin miscompares++; $display("FAIL ill_flw got ill=%b fv=%b exp 1 0", bus.illegal_o, bus.falu_valid_o); end
        bus.frm_i = 3'b110;
        drive(1'b1, OP_FADDS, 3'b111, 2'b00, 4'd3);
        step();
        vectors++; if (bus.illegal_o !== 1'b1 || bus.falu_valid_o !== 1'b0) begin miscompares++; $display("FAIL ill_frm got ill=%b fv=%b exp 1 0", bus.illegal_o, bus.falu_valid_o); end
        bus.frm_i = 3'b000;
        drive(1'b1, OP_NONE, 3'b000, 2'b00, 4'd4);
        step();
        vectors++; if (bus.illegal_o !== 1'b1) begin miscompares++; $display("FAIL ill_none got %b exp 1", bus.illegal_o); end
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        step();
        vectors++; if (bus.illegal_o !== 1'b0) begin miscompares++; $display("FAIL ill_pulse got %b exp 0", bus.illegal_o); end
        idle_cycles(5);
        vectors++; if (bus.wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL ill_no_wb got %b exp 0", bus.wb_valid_o); end
    endtask

    task automatic test_flush();
        drive(1'b1, OP_DIVS, 3'b000, 2'b00, 4'd4);
        step();
        drive(1'b1, OP_FADDS, 3'b000, 2'b00, 4'd6);
        step();
        drive(1'b1, OP_FMULS, 3'b000, 2'b00, 4'd7);
        step();
        bus.flush_i = 1'b1;
        drive(1'b1, OP_FADDS, 3'b000, 2'b00, 4'd8);
        vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL fl_ready got %b exp 0", bus.ready_o); end
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, OP_FADDS, 3'b000, 2'b00, '0);
        vectors++; if (bus.ds_kill_o !== 1'b1 || bus.falu_valid_o !== 1'b0) begin miscompares++; $display("FAIL fl_kill got kill=%b fv=%b exp 1 0", bus.ds_kill_o, bus.falu_valid_o); end
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL fl_ready_after got %b exp 1", bus.ready_o); end
        for (int c = 0; c < 8; c++) begin
            bus.ds_done_i = (c == 2);
            step();
            vectors++; if (bus.wb_valid_o !== 1'b0 || bus.ds_kill_o !== 1'b0) begin miscompares++; $display("FAIL fl_quiet[%0d] got wb=%b kill=%b exp 0 0", c, bus.wb_valid_o, bus.ds_kill_o); end
        end
        bus.ds_done_i = 1'b0;
        drive(1'b1, OP_DIVS, 3'b000, 2'b00, 4'd2);
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL fl_ds_idle got %b exp 1", bus.ready_o); end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_falu_single();
        test_back_to_back();
        test_divsqrt();
        test_conflict();
        test_illegal();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
